// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words
// and writes them to consecutive word addresses while holding the CPU in reset.
module imem_loader #(
    parameter int unsigned DEPTH = 65,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [6:0]    word_count,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          WE,
    output logic [AW-1:0] WA,
    output logic [31:0]   WD,
    output logic          busy,
    output logic          cpu_hold,
    output logic          done
);

    localparam int unsigned CW = (DEPTH < 2) ? 1 : $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] addr;
    logic [1:0]    idx;

    logic          take_byte_c;
    logic [CW-1:0] addr_inc_c;

    // byte_ready is a registered copy of (state == LOAD), so it qualifies the handshake directly
    assign take_byte_c = byte_valid && byte_ready;
    assign addr_inc_c  = addr + CW'(1);

    // Single-process FSM; every output register is loaded with its next-state value
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            addr       <= '0;
            idx        <= '0;
            byte_ready <= 1'b0;
            WE         <= 1'b0;
            WA         <= '0;
            WD         <= '0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
        end else begin
            WE   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr <= '0;
                        idx  <= '0;
                        if (word_count == 7'd0) begin
                            count <= '0;
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // Clamp so WA can never run past the end of the memory
                            if (32'(word_count) > DEPTH) begin
                                count <= CW'(DEPTH);
                            end else begin
                                count <= CW'(word_count);
                            end
                            state      <= LOAD;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            cpu_hold   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (take_byte_c) begin
                        case (idx)
                            2'd0:    WD[31:24] <= byte_data;
                            2'd1:    WD[23:16] <= byte_data;
                            2'd2:    WD[15:8]  <= byte_data;
                            default: WD[7:0]   <= byte_data;
                        endcase
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            WE         <= 1'b1;
                            WA         <= AW'(addr);
                        end
                    end
                end
                WRITE: begin
                    addr <= addr_inc_c;
                    if (addr_inc_c == count) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else begin
                        state      <= LOAD;
                        idx        <= '0;
                        byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: transaction-level reference model checked every
// cycle, plus literal expectations for the write log of each scenario.
module tb_imem_loader;

    localparam int DEPTH = 65;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        WE;
    logic [31:0] WA;
    logic [31:0] WD;
    logic        busy;
    logic        cpu_hold;
    logic        done;

    imem_loader #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .word_count(word_count),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .WE        (WE),
        .WA        (WA),
        .WD        (WD),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the load as counts of bytes accepted and words written
    logic        exp_ready = 1'b0;
    logic        exp_we    = 1'b0;
    logic        exp_done  = 1'b0;
    logic        exp_busy  = 1'b0;
    logic [31:0] exp_wa    = '0;
    logic [31:0] exp_wd    = '0;
    int          m_ww = 0;
    int          m_nb = 0;
    int          m_tgt = 0;

    always @(posedge clk) begin : model
        int          ww, nb, tgt;
        logic        rdy, we, dn, act;
        logic [31:0] wd, wa;
        ww = m_ww; nb = m_nb; tgt = m_tgt;
        rdy = exp_ready; act = exp_busy; wd = exp_wd; wa = exp_wa;
        we = 1'b0; dn = 1'b0;
        if (reset) begin
            ww = 0; nb = 0; tgt = 0; rdy = 1'b0; act = 1'b0; wd = '0; wa = '0;
        end else if (exp_we) begin
            ww++;
            if (ww == tgt) begin
                dn = 1'b1; act = 1'b0; rdy = 1'b0;
            end else begin
                rdy = 1'b1;
            end
        end else if (exp_done) begin
            act = 1'b0;
        end else if (!act) begin
            if (start) begin
                tgt = (int'(word_count) > DEPTH) ? DEPTH : int'(word_count);
                ww = 0; nb = 0;
                if (tgt == 0) dn = 1'b1;
                else begin act = 1'b1; rdy = 1'b1; end
            end
        end else if (rdy && byte_valid) begin
            wd[31 - 8 * (nb % 4) -: 8] = byte_data;
            nb++;
            if (nb % 4 == 0) begin
                we = 1'b1; wa = 32'(ww); rdy = 1'b0;
            end
        end
        m_ww <= ww; m_nb <= nb; m_tgt <= tgt;
        exp_ready <= rdy; exp_we <= we; exp_done <= dn; exp_busy <= act;
        exp_wd <= wd; exp_wa <= wa;
    end

    typedef struct { logic [31:0] wa; logic [31:0] wd; } wr_t;
    wr_t  wlog[$];
    int   done_cnt = 0;
    logic ready_seen = 1'b0;
    logic cmp_en = 1'b0;

    // Per-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("byte_ready", 64'(byte_ready), 64'(exp_ready));
            chk("WE",         64'(WE),         64'(exp_we));
            chk("done",       64'(done),       64'(exp_done));
            chk("busy",       64'(busy),       64'(exp_busy));
            chk("cpu_hold",   64'(cpu_hold),   64'(exp_busy));
            chk("WA",         64'(WA),         64'(exp_wa));
            chk("WD",         64'(WD),         64'(exp_wd));
            if (WE === 1'b1) wlog.push_back('{wa: WA, wd: WD});
            if (done === 1'b1) done_cnt++;
            if (byte_ready === 1'b1) ready_seen = 1'b1;
        end
    end

    task automatic do_start(input int wc);
        start = 1'b1;
        word_count = 7'(wc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("push_timeout", 64'(t), 64'(0));
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("idle_timeout", 64'(t), 64'(0));
        @(negedge clk);
    endtask

    task automatic clear_log();
        wlog.delete();
        done_cnt = 0;
        ready_seen = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(byte_ready), 64'(0));
        chk({tag, "_we"},    64'(WE),         64'(0));
        chk({tag, "_wa"},    64'(WA),         64'(0));
        chk({tag, "_wd"},    64'(WD),         64'(0));
        chk({tag, "_busy"},  64'(busy),       64'(0));
        chk({tag, "_hold"},  64'(cpu_hold),   64'(0));
        chk({tag, "_done"},  64'(done),       64'(0));
    endtask

    logic [7:0] seq_a [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h00};
    logic [7:0] seq_b [4] = '{8'h8C, 8'h03, 8'h00, 8'h04};

    initial begin
        reset = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // Two words back-to-back
        clear_log();
        do_start(2);
        for (int i = 0; i < 8; i++) push(seq_a[i]);
        wait_idle();
        chk("a_nwr", 64'(wlog.size()), 64'(2));
        if (wlog.size() == 2) begin
            chk("a_wa0", 64'(wlog[0].wa), 64'(0));
            chk("a_wd0", 64'(wlog[0].wd), 64'h20080005);
            chk("a_wa1", 64'(wlog[1].wa), 64'(1));
            chk("a_wd1", 64'(wlog[1].wd), 64'hAC020000);
        end
        chk("a_done", 64'(done_cnt), 64'(1));
        chk("a_busy", 64'(busy), 64'(0));

        // One word with a one-cycle gap after every byte
        clear_log();
        do_start(1);
        for (int i = 0; i < 4; i++) begin
            push(seq_b[i]);
            @(negedge clk);
        end
        wait_idle();
        chk("b_nwr", 64'(wlog.size()), 64'(1));
        if (wlog.size() == 1) begin
            chk("b_wa", 64'(wlog[0].wa), 64'(0));
            chk("b_wd", 64'(wlog[0].wd), 64'h8C030004);
        end

        // Zero-length load
        clear_log();
        do_start(0);
        chk("z_done", 64'(done), 64'(1));
        repeat (3) @(negedge clk);
        chk("z_nwr", 64'(wlog.size()), 64'(0));
        chk("z_ready", 64'(ready_seen), 64'(0));
        chk("z_donecnt", 64'(done_cnt), 64'(1));

        // Oversized request clamps to DEPTH words
        clear_log();
        do_start(100);
        for (int i = 0; i < DEPTH * 4; i++) push(8'(i * 7 + 3));
        wait_idle();
        chk("c_nwr", 64'(wlog.size()), 64'(DEPTH));
        for (int i = 0; i < wlog.size(); i++) chk("c_wa", 64'(wlog[i].wa), 64'(i));
        if (wlog.size() == DEPTH) chk("c_wd_last", 64'(wlog[DEPTH-1].wd), 64'h030A1118);
        chk("c_done", 64'(done_cnt), 64'(1));

        // Reset in the middle of the second word of a three-word load
        clear_log();
        do_start(3);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55); push(8'h66);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid");
        reset = 1'b0;
        chk("mid_nwr", 64'(wlog.size()), 64'(1));
        @(negedge clk);
        clear_log();
        do_start(1);
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        wait_idle();
        chk("r_nwr", 64'(wlog.size()), 64'(1));
        if (wlog.size() == 1) begin
            chk("r_wa", 64'(wlog[0].wa), 64'(0));
            chk("r_wd", 64'(wlog[0].wd), 64'hAABBCCDD);
        end

        // start pulses during LOAD and WRITE are ignored
        clear_log();
        do_start(2);
        push(8'h01); push(8'h02);
        do_start(5);
        push(8'h03); push(8'h04);
        do_start(7);
        push(8'h05); push(8'h06); push(8'h07); push(8'h08);
        wait_idle();
        chk("s_nwr", 64'(wlog.size()), 64'(2));
        if (wlog.size() == 2) begin
            chk("s_wa0", 64'(wlog[0].wa), 64'(0));
            chk("s_wd0", 64'(wlog[0].wd), 64'h01020304);
            chk("s_wa1", 64'(wlog[1].wa), 64'(1));
            chk("s_wd1", 64'(wlog[1].wd), 64'h05060708);
        end
        chk("s_done", 64'(done_cnt), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001: Parameter DEPTH, default 65, number of 32-bit words in the instruction memory being loaded.
REQ-002: Parameter AW, default 32, width of the word address output.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006: word_count  input  7  number of words to load; sampled with start.
REQ-007: byte_valid  input  1  byte_data holds a valid program byte.
REQ-008: byte_data  input  8  program byte stream, big-endian within each word.
REQ-009: byte_ready  output  1  loader accepts a byte this cycle.
REQ-010: WE  output  1  instruction memory write enable, one-cycle pulse per word.
REQ-011: WA  output  AW  word address of the write, zero-extended, indexed exactly as the memory read port A.
REQ-012: WD  output  32  assembled instruction word.
REQ-013: busy  output  1  high in LOAD and WRITE.
REQ-014: cpu_hold  output  1  holds the processor in reset while the memory is being written; equals busy.
REQ-015: done  output  1  one-cycle pulse on load completion.

Function
REQ-016: FSM states: IDLE, LOAD, WRITE, DONE; encoding is free.
REQ-017: IDLE: byte_ready=0, WE=0, busy=0, done=0; start=1 latches count=min(word_count, DEPTH), clears addr and byte index, and moves to LOAD.
REQ-018: start with word_count=0 moves IDLE->DONE directly, with no byte accepted and no write issued.
REQ-019: LOAD: byte_ready=1; a byte transfers only on a cycle where byte_valid=1 and byte_ready=1.
REQ-020: Transfer k (k=0..3) of a word places byte_data in WD[31-8k:24-8k]; WD holds its value between transfers.
REQ-021: The 4th transfer moves LOAD->WRITE; byte_ready=0 in WRITE, so no byte is lost or accepted there.
REQ-022: WRITE lasts exactly one cycle with WE=1, WA=addr, WD=the complete word.
REQ-023: Latency: WE is high in the cycle immediately after the edge that accepted the 4th byte.
REQ-024: On leaving WRITE, addr increments; if the incremented addr equals count, next state is DONE, else LOAD with byte index cleared.
REQ-025: DONE lasts one cycle with done=1, then returns to IDLE; addr, WA and WD retain their last values.
REQ-026: byte_valid gaps of any length in LOAD stall the loader with no timeout; state is unchanged.
REQ-027: start is ignored in LOAD, WRITE and DONE.
REQ-028: WA never exceeds DEPTH-1; word_count>DEPTH loads exactly DEPTH words.
REQ-029: WE is never high outside WRITE; at most one write occurs per word.

Reset
REQ-030: While reset=1 at a rising edge: state<=IDLE, addr<=0, byte index<=0, WD<=0, count<=0.
REQ-031: Outputs after a reset edge: byte_ready=0, WE=0, WA=0, WD=0, busy=0, cpu_hold=0, done=0.
REQ-032: Reset has priority over start and byte_valid in the same cycle.
REQ-033: Reset mid-load discards any partial word without a write; previously written memory words are not modified.

Verification
REQ-034: reset, start with word_count=2, bytes 20 08 00 05 AC 02 00 00 back-to-back -> WE pulses twice: WA=0 WD=0x20080005, then WA=1 WD=0xAC020000; done pulses once; busy=0 afterwards.
REQ-035: word_count=1 with byte_valid toggling every other cycle -> exactly 4 transfers; WD=0x8C030004 at WA=0; WE high one cycle after the 4th accepted byte.
REQ-036: start with word_count=0 -> done=1 on the next cycle, WE never high, byte_ready never high.
REQ-037: word_count=100 -> exactly 65 writes, WA=0..64 in order, then done.
REQ-038: Reset asserted after 2 bytes of word 1 in a 3-word load -> no WE for word 1, outputs at reset values, then a new start loads from WA=0.
REQ-039: start pulsed during LOAD and during WRITE -> ignored; addr sequence and write count unchanged.
